// File: rtl/shift_seq_ctrl_amisha.sv
// Full-duplex LSB-first serial shift sequencer: loads a parallel word over valid/ready,
// shifts a programmable number of bits out while capturing, and returns the captured word.
module shift_seq_ctrl_amisha #(
    parameter int N_amisha   = 8,
    parameter int GAP_amisha = 0,
    parameter int CW_amisha  = $clog2(N_amisha) + 1
) (
    input  logic                 clk_amisha,
    input  logic                 reset_n_amisha,
    input  logic [N_amisha-1:0]  tx_data_amisha,
    input  logic [CW_amisha-1:0] tx_len_amisha,
    input  logic                 tx_valid_amisha,
    output logic                 tx_ready_amisha,
    input  logic                 abort_amisha,
    input  logic                 s_in_amisha,
    output logic                 s_out_amisha,
    output logic                 shift_en_amisha,
    output logic [N_amisha-1:0]  rx_data_amisha,
    output logic                 rx_valid_amisha,
    output logic                 busy_amisha,
    output logic [1:0]           state_dbg_amisha
);

    // Handshake: a word transfers on any rising edge where tx_valid_amisha and
    // tx_ready_amisha are both high; tx_ready_amisha is high only in IDLE and does
    // not depend on tx_valid_amisha.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [N_amisha-1:0]   sreg_q, sreg_d;
    logic [CW_amisha-1:0]  cnt_q, cnt_d;
    logic [CW_amisha-1:0]  len_q, len_d;
    logic [3:0]            gap_q, gap_d;
    logic [N_amisha-1:0]   rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;

    logic [N_amisha-1:0]   shifted;
    logic [CW_amisha-1:0]  len_eff;
    logic [CW_amisha-1:0]  shamt;

    assign shifted = {s_in_amisha, sreg_q[N_amisha-1:1]};
    assign len_eff = ((tx_len_amisha == '0) || (tx_len_amisha > CW_amisha'(N_amisha)))
                     ? CW_amisha'(N_amisha) : tx_len_amisha;
    // Captured bits accumulate at the top of the register; this right-aligns them.
    assign shamt   = CW_amisha'(N_amisha) - len_q;

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        gap_d      = gap_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid_amisha) begin
                    sreg_d  = tx_data_amisha;
                    len_d   = len_eff;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_amisha) begin
                    sreg_d  = '0;
                    state_d = IDLE;
                end else begin
                    sreg_d = shifted;
                    cnt_d  = cnt_q + CW_amisha'(1);
                    if (cnt_q == len_q - CW_amisha'(1)) begin
                        rx_data_d  = shifted >> shamt;
                        rx_valid_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (abort_amisha) begin
                    sreg_d  = '0;
                    state_d = IDLE;
                end else if (GAP_amisha > 0) begin
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if ({1'b0, gap_q} + 5'd1 == 5'(GAP_amisha)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready_amisha  = (state_q == IDLE);
    assign shift_en_amisha  = (state_q == SHIFT);
    assign s_out_amisha     = shift_en_amisha & sreg_q[0];
    assign busy_amisha      = (state_q != IDLE);
    assign rx_data_amisha   = rx_data_q;
    assign rx_valid_amisha  = rx_valid_q;
    assign state_dbg_amisha = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl_amisha.sv
// Bench for shift_seq_ctrl_amisha: one instance with no inter-frame gap, one with a
// two-cycle gap; serial bits and returned words are checked against expected queues.
module tb_shift_seq_ctrl_amisha;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       loop_en;

    logic [7:0] a_tx_data, a_rx_data;
    logic [3:0] a_tx_len;
    logic       a_tx_valid, a_tx_ready, a_abort, a_s_in, a_s_in_drv, a_s_out;
    logic       a_shift_en, a_rx_valid, a_busy;
    logic [1:0] a_state;

    logic [7:0] b_tx_data, b_rx_data;
    logic [3:0] b_tx_len;
    logic       b_tx_valid, b_tx_ready, b_abort, b_s_in, b_s_out;
    logic       b_shift_en, b_rx_valid, b_busy;
    logic [1:0] b_state;

    assign a_s_in = loop_en ? a_s_out : a_s_in_drv;

    shift_seq_ctrl_amisha #(.N_amisha(8), .GAP_amisha(0)) dut_a (
        .clk_amisha(clk), .reset_n_amisha(rst_n),
        .tx_data_amisha(a_tx_data), .tx_len_amisha(a_tx_len),
        .tx_valid_amisha(a_tx_valid), .tx_ready_amisha(a_tx_ready),
        .abort_amisha(a_abort), .s_in_amisha(a_s_in), .s_out_amisha(a_s_out),
        .shift_en_amisha(a_shift_en), .rx_data_amisha(a_rx_data),
        .rx_valid_amisha(a_rx_valid), .busy_amisha(a_busy),
        .state_dbg_amisha(a_state)
    );

    shift_seq_ctrl_amisha #(.N_amisha(8), .GAP_amisha(2)) dut_b (
        .clk_amisha(clk), .reset_n_amisha(rst_n),
        .tx_data_amisha(b_tx_data), .tx_len_amisha(b_tx_len),
        .tx_valid_amisha(b_tx_valid), .tx_ready_amisha(b_tx_ready),
        .abort_amisha(b_abort), .s_in_amisha(b_s_in), .s_out_amisha(b_s_out),
        .shift_en_amisha(b_shift_en), .rx_data_amisha(b_rx_data),
        .rx_valid_amisha(b_rx_valid), .busy_amisha(b_busy),
        .state_dbg_amisha(b_state)
    );

    int checks = 0;
    int errors = 0;
    logic       sout_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] b_exp_q[$];
    logic [7:0] last_rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents a serial bit or a returned word.
    always @(negedge clk) begin
        if (a_shift_en === 1'b1) begin
            if (sout_q.size() == 0) check("a_unexpected_shift", a_shift_en, 0);
            else check("a_s_out", a_s_out, sout_q.pop_front());
        end
        if (a_rx_valid === 1'b1) begin
            if (exp_q.size() == 0) check("a_unexpected_rx_valid", a_rx_valid, 0);
            else check("a_rx_data", a_rx_data, exp_q.pop_front());
        end
        if (b_rx_valid === 1'b1) begin
            if (b_exp_q.size() == 0) check("b_unexpected_rx_valid", b_rx_valid, 0);
            else check("b_rx_data", b_rx_data, b_exp_q.pop_front());
        end
    end

    // One frame on dut_a; abort_at is the 1-based shift cycle carrying abort (0 = none).
    task automatic send(input logic [7:0] d, input logic [3:0] len, input logic [7:0] sin,
                        input int abort_at, input string tag);
        int leff, shifts, n;
        logic [7:0] exp_rx;
        leff   = (len == 0 || len > 8) ? 8 : int'(len);
        shifts = (abort_at > 0) ? abort_at : leff;
        for (int i = 0; i < shifts; i++) sout_q.push_back(d[i]);
        if (abort_at == 0) begin
            exp_rx  = sin & 8'((1 << leff) - 1);
            exp_q.push_back(exp_rx);
        end
        a_tx_data  = d;
        a_tx_len   = len;
        a_tx_valid = 1'b1;
        n = 0;
        while (!a_tx_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!a_tx_ready) check({tag, "_ready_timeout"}, a_tx_ready, 1);
        @(posedge clk); #1;
        a_tx_valid = 1'b0;
        for (int i = 0; i < shifts; i++) begin
            check({tag, "_shift_en"}, a_shift_en, 1);
            a_s_in_drv = sin[i];
            a_abort    = (i + 1 == abort_at);
            @(posedge clk); #1;
        end
        a_abort = 1'b0;
        if (abort_at > 0) begin
            check({tag, "_abort_ready"}, a_tx_ready, 1);
            check({tag, "_abort_busy"}, a_busy, 0);
            check({tag, "_abort_rx_hold"}, a_rx_data, last_rx);
        end else begin
            check({tag, "_len_end"}, a_shift_en, 0);
            check({tag, "_rx_valid_latency"}, a_rx_valid, 1);
            @(posedge clk); #1;
            check({tag, "_ready_after"}, a_tx_ready, 1);
            check({tag, "_rx_valid_pulse"}, a_rx_valid, 0);
            last_rx = exp_rx;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b1; loop_en = 1'b0; last_rx = 8'h00;
        a_tx_data = '0; a_tx_len = '0; a_tx_valid = 1'b0; a_abort = 1'b0; a_s_in_drv = 1'b0;
        b_tx_data = '0; b_tx_len = '0; b_tx_valid = 1'b0; b_abort = 1'b0; b_s_in = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_ready", a_tx_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_shift_en", a_shift_en, 0);
        check("rst_rx_data", a_rx_data, 0);
        check("rst_b_ready", b_tx_ready, 1);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        loop_en = 1'b1;
        send(8'hA5, 4'd0, 8'hA5, 0, "full_loop");
        loop_en = 1'b0;
        send(8'h06, 4'd3, 8'b0000_0011, 0, "short");
        send(8'h5A, 4'd12, 8'h3C, 0, "clamp");
        send(8'hFF, 4'd0, 8'h00, 4, "abort_mid");
        send(8'h81, 4'd5, 8'h1F, 5, "abort_last");
        send(8'h00, 4'd2, 8'b0000_0010, 0, "post_abort");

        // Back-to-back on the no-gap instance: 8 shifts + DONE between handshakes.
        for (int i = 0; i < 8; i++) sout_q.push_back(((8'h3C >> i) & 8'h01) != 0);
        for (int i = 0; i < 8; i++) sout_q.push_back(((8'hC3 >> i) & 8'h01) != 0);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        a_s_in_drv = 1'b1; a_tx_len = 4'd0; a_tx_data = 8'h3C; a_tx_valid = 1'b1;
        n = 0;
        while (!a_tx_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        a_tx_data = 8'hC3;
        n = 0;
        while (!a_tx_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("b2b_gap0_ready_low", n, 9);
        @(posedge clk); #1;
        a_tx_valid = 1'b0;
        check("b2b_gap0_second_start", a_shift_en, 1);
        repeat (10) begin @(posedge clk); #1; end
        last_rx = 8'hFF;

        // Gap instance: ready low for 8+1+2 cycles; abort during GAP must be ignored.
        b_exp_q.push_back(8'hFF); b_exp_q.push_back(8'hFF);
        b_s_in = 1'b1; b_tx_len = 4'd0; b_tx_data = 8'h01; b_tx_valid = 1'b1;
        n = 0;
        while (!b_tx_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        b_tx_data = 8'h80;
        n = 0;
        while (!b_tx_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
            b_abort = (n == 9);
        end
        b_abort = 1'b0;
        check("gap2_ready_low", n, 11);
        @(posedge clk); #1;
        b_tx_valid = 1'b0;
        check("gap2_second_start", b_shift_en, 1);
        check("gap2_second_first_bit", b_s_out, 0);
        repeat (14) begin @(posedge clk); #1; end
        check("gap2_idle_after", b_busy, 0);

        // Asynchronous reset in the fourth shift cycle of a frame.
        for (int i = 0; i < 3; i++) sout_q.push_back(1'b1);
        a_tx_data = 8'hFF; a_tx_len = 4'd0; a_tx_valid = 1'b1;
        n = 0;
        while (!a_tx_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        a_tx_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_busy_before_reset", a_busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_s_out", a_s_out, 0);
        check("async_rst_shift_en", a_shift_en, 0);
        check("async_rst_rx_valid", a_rx_valid, 0);
        check("async_rst_busy", a_busy, 0);
        check("async_rst_tx_ready", a_tx_ready, 1);
        check("async_rst_rx_data", a_rx_data, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("post_rst_idle", a_busy, 0);

        repeat (3) @(posedge clk);
        check("sout_q_drained", sout_q.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("b_exp_q_drained", b_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_seq_ctrl_amisha.md
Name: shift_seq_ctrl_amisha

Overview:
- Sequencer for an N-bit right-shifting (LSB-first) serial shift register. The register is held internally.
- Accepts a parallel word over a valid/ready handshake, loads it, and shifts a programmable number of bits out on s_out_amisha while capturing s_in_amisha.
- Returns the captured word right-aligned with a one-cycle valid pulse.
- Sits between a parallel producer/consumer and a serial link (SPI-like full duplex).

Parameters:
- N_amisha, 8: shift register width and maximum frame length; must be >= 2.
- GAP_amisha, 0: idle cycles inserted after each frame before the next word is accepted; range 0..15.
- CW_amisha, $clog2(N_amisha)+1: width of the length field and bit counter; derived, do not override.

Ports:
- clk_amisha  in  1  clock; all state changes on the rising edge.
- reset_n_amisha  in  1  reset; asynchronous assert, active-low.
- tx_data_amisha  in  N_amisha  parallel word to shift out, LSB first.
- tx_len_amisha  in  CW_amisha  bits per frame. 0 or any value > N_amisha means N_amisha.
- tx_valid_amisha  in  1  producer has a word.
- tx_ready_amisha  out  1  controller can accept a word.
- abort_amisha  in  1  synchronous frame abort.
- s_in_amisha  in  1  serial input, sampled on each shift edge.
- s_out_amisha  out  1  serial output.
- shift_en_amisha  out  1  high on cycles in which a bit is presented and shifted.
- rx_data_amisha  out  N_amisha  captured word, right-aligned.
- rx_valid_amisha  out  1  one-cycle pulse when rx_data_amisha is updated.
- busy_amisha  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset_n_amisha=0), applied immediately regardless of clock:
  - state=IDLE; shift register, counter, gap counter, latched length and rx_data_amisha all cleared to 0.
  - s_out_amisha=0, shift_en_amisha=0, rx_valid_amisha=0, busy_amisha=0.
  - tx_ready_amisha=1, since it is decoded from IDLE.
  - Reset mid-frame discards the frame; no rx_valid_amisha pulse is produced.
- States: IDLE, SHIFT, DONE, GAP.
- IDLE:
  - tx_ready_amisha=1, s_out_amisha=0, shift_en_amisha=0.
  - On tx_valid_amisha & tx_ready_amisha: shift register <= tx_data_amisha; L <= effective length; counter <= 0; go to SHIFT.
  - abort_amisha is ignored in IDLE.
- SHIFT:
  - tx_ready_amisha=0, shift_en_amisha=1, s_out_amisha=sreg[0] (combinational from the register).
  - Each edge: sreg <= {s_in_amisha, sreg[N-1:1]}; counter++.
  - The edge on which counter == L-1 performs the last shift, then goes to DONE. SHIFT therefore lasts exactly L cycles.
- DONE (1 cycle):
  - rx_valid_amisha=1 (registered pulse).
  - rx_data_amisha = sreg >> (N_amisha-L): the last L captured bits, first-captured bit at bit 0, upper bits zero.
  - Next state: GAP if GAP_amisha>0, otherwise IDLE.
- GAP: holds for exactly GAP_amisha cycles with tx_ready_amisha=0, then goes to IDLE.
- Latency: handshake at edge k gives shift cycles k+1..k+L, rx_valid_amisha in cycle k+L+1, and tx_ready_amisha high again in cycle k+L+2+GAP_amisha.
- Back-to-back: with tx_valid_amisha held high and GAP_amisha=0, frames are separated by exactly one non-shift cycle (DONE) plus one IDLE accept cycle.
- abort_amisha in SHIFT or DONE:
  - Next state is IDLE; GAP is skipped.
  - rx_valid_amisha is not asserted and rx_data_amisha keeps its previous value.
  - Shift register is cleared.
  - If the abort arrives in the same cycle as the last shift, the abort wins.
- abort_amisha in GAP: ignored; the gap completes.
- rx_data_amisha changes only in DONE, and holds its value between frames.
- s_out_amisha and s_in_amisha carry no framing; any framing belongs to the user of shift_en_amisha.

Test Plan:
- Reset check: assert reset_n_amisha=0 mid-SHIFT -> s_out_amisha, shift_en_amisha, rx_valid_amisha, busy_amisha all go 0 and tx_ready_amisha goes 1 without waiting for a clock edge; release -> IDLE, no rx_valid_amisha pulse.
- Full frame, N=8, GAP=0, tx_len=0: send 0xA5 with s_in_amisha looped to s_out_amisha -> s_out_amisha sequence 1,0,1,0,0,1,0,1 over 8 shift_en_amisha cycles; rx_data_amisha=0xA5 with a 1-cycle rx_valid_amisha in cycle k+9.
- Short frame: tx_len=3, data 0x06, s_in_amisha driven 1,1,0 -> 3 shift cycles with s_out_amisha 0,1,1; rx_data_amisha=0x03.
- Clamp: tx_len=12 with N=8 -> exactly 8 shift cycles.
- Gap and back-to-back: GAP=2, tx_valid_amisha held high with 0x01 then 0x80 -> tx_ready_amisha low for 8+1+2 cycles between handshakes; second frame starts in cycle k+13.
- Abort: abort_amisha on the 4th shift cycle of 0xFF -> next cycle IDLE, tx_ready_amisha=1, no rx_valid_amisha, rx_data_amisha unchanged from the prior frame. Abort coincident with the last shift -> no rx_valid_amisha.
